seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor of the single-cycle datapath ALU.
- Keeps the existing 4-bit operation encoding for logic, shift, add, subtract and compare.
- Adds iterative multiply and unsigned divide/remainder, run by a small FSM.
- Sits between the decode/operand stage and writeback; the stall logic uses in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block can accept a new operation.
- op  input  4  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered together with result.
- illegal  output  1  op was not a defined code.
- overflow  output  1  present only with SEQ_ALU_OVF_EN.

Behaviour:
- Op codes, single-cycle class:
  - 0000 AND; 0001 OR; 0010 ADD; 0100 XOR.
  - 0101 SLL by b[SHW-1:0]; 0110 SUB.
  - 0111 SLT, signed, result 1 or 0; 1101 SRA by b[SHW-1:0].
- Op codes, multi-cycle class:
  - 1000 MUL, low WIDTH bits of the product.
  - 1001 MULHU, high WIDTH bits of the unsigned product.
  - 1010 DIVU; 1011 REMU.
- Any other op: result=0, zero=1, illegal=1; handled in the single-cycle class.
- Arithmetic wraps modulo 2^WIDTH.
- Reset: FSM to IDLE. in_ready=1, out_valid=0, result=0, zero=1, illegal=0, overflow=0. Internal accumulators cleared.
- FSM states IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - Accept occurs when in_valid && in_ready; op, a and b are latched.
- IDLE, single-cycle accept: compute and register the result, go to DONE. out_valid rises on the next edge (latency 1).
- IDLE, multi-cycle accept: load the iteration counter with WIDTH and go to BUSY.
  - MUL/MULHU: shift-add, one multiplier bit per cycle.
  - DIVU/REMU: restoring division, one quotient bit per cycle.
- BUSY:
  - Counter decrements each cycle.
  - When the counter reaches 0, register the final result and go to DONE.
  - out_valid is first high WIDTH+1 cycles after the accept edge.
- DONE: out_valid=1; result, zero and illegal held stable. On out_ready=1, go to IDLE, so in_ready returns the following cycle.
- No accept in BUSY or DONE. in_valid is ignored there, and the upstream must hold its request.
- Divide by zero: DIVU gives all ones; REMU gives a.
  - Takes the same WIDTH+1 latency; no early exit.
- out_ready while out_valid=0 has no effect.
- rst_n low mid-operation: immediate abort to the reset values; no partial result is ever signalled.

Optional Feature:
- Macro SEQ_ALU_OVF_EN.
- Defined:
  - overflow port present and registered with result.
  - Set for ADD when operand signs are equal and the result sign differs.
  - Set for SUB when operand signs differ and the result sign differs from a.
  - 0 for all other ops; reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then single ops, WIDTH=32:
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, out_valid 1 cycle after accept, overflow=1 when enabled.
  - SUB 5-5 -> 0 with zero=1.
- Shifts and compare:
  - SRA 0x80000000 by b=0x24 (amount 4) -> 0xF8000000.
  - SLL 1 by 31 -> 0x80000000.
  - SLT -1,1 -> 1.
- Multiply:
  - MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
  - MULHU same operands -> 0x00000001.
  - Each out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- Divide:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Backpressure and illegal op:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored.
  - op=1111 -> result 0, zero=1, illegal=1.
- Reset mid-divide:
  - Assert rst_n=0 at cycle 10 of BUSY -> outputs at reset values immediately.
  - After release, a new ADD 2+3 -> 5 with latency 1.

Source files
------------

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : handshaked sequential ALU
//
// Sits between the decode/operand stage and writeback. The single-cycle ops
// (logic, shift, add, sub, signed compare) and undefined op codes are done at
// the accept edge. MUL/MULHU use shift-add and DIVU/REMU use restoring
// division, one bit per cycle for WIDTH cycles.
//
// Optional feature: define SEQ_ALU_OVF_EN to add the signed-overflow output
// for ADD/SUB.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   op/a/b presented
//   in_ready   out  block is idle and can accept an operation
//   op         in   4-bit operation code
//   a, b       in   WIDTH-bit operands (shift amount is b[SHW-1:0])
//   out_valid  out  result available (held until out_ready)
//   out_ready  in   consumer takes the result
//   result     out  registered WIDTH-bit result
//   zero       out  result == 0, registered with result
//   illegal    out  op was not a defined code
//   overflow   out  signed ADD/SUB overflow (only with SEQ_ALU_OVF_EN)
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int SHW = $clog2(WIDTH);
  // Counter must hold the value WIDTH itself.
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // MUL, MULHU, DIVU, REMU all share the 10xx prefix.
  function automatic logic is_multi(input logic [3:0] o);
    return (o[3:2] == 2'b10);
  endfunction

  function automatic logic is_legal_single(input logic [3:0] o);
    case (o)
      OP_AND, OP_OR, OP_ADD, OP_XOR,
      OP_SLL, OP_SUB, OP_SLT, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] single_result(
    input logic [3:0]       o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic signed [WIDTH-1:0] sra;
    logic        [SHW-1:0]   sh;
    xs  = x;
    ys  = y;
    sh  = y[SHW-1:0];
    sra = xs >>> sh;
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_XOR:  return x ^ y;
      OP_SLL:  return x << sh;
      OP_SUB:  return x - y;
      OP_SLT:  return (xs < ys) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      OP_SRA:  return sra;
      default: return '0;
    endcase
  endfunction

`ifdef SEQ_ALU_OVF_EN
  // Same-sign operands whose sum flips sign.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    s = x + y;
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Opposite-sign operands whose difference takes the sign of b.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    s = x - y;
    return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction
`endif

  state_t           state_q,   state_d;
  logic [1:0]       opsel_q,   opsel_d;   // op[1:0] of the multi-cycle op
  logic [WIDTH-1:0] opnd_q,    opnd_d;    // multiplicand or divisor
  logic [WIDTH-1:0] acc_q,     acc_d;     // product high half / remainder
  logic [WIDTH-1:0] lo_q,      lo_d;      // multiplier->product low / dividend->quotient
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             illegal_q, illegal_d;
`ifdef SEQ_ALU_OVF_EN
  logic             ovf_q,     ovf_d;
`endif

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_n;
  logic [WIDTH-1:0] div_lo_n;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] fin_res;

  always_comb begin
    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, acc, lo} product right by one.
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. A zero divisor always "fits",
    // which yields an all-ones quotient and leaves the dividend as remainder;
    // it is forced explicitly because the shifted value can exceed WIDTH bits.
    div_trial = {acc_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    div_ge    = ~div_trial[WIDTH] | (opnd_q == '0);
    div_acc_n = div_ge ? div_trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
    div_lo_n  = {lo_q[WIDTH-2:0], div_ge};

    sc_res = single_result(op, a, b);

    case (opsel_q)
      2'b00:   fin_res = mul_lo_n;
      2'b01:   fin_res = mul_acc_n;
      2'b10:   fin_res = div_lo_n;
      default: fin_res = div_acc_n;
    endcase

    state_d   = state_q;
    opsel_d   = opsel_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef SEQ_ALU_OVF_EN
    ovf_d     = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_multi(op)) begin
            opsel_d = op[1:0];
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            if (op[1]) begin
              lo_d   = a;
              opnd_d = b;
            end else begin
              lo_d   = b;
              opnd_d = a;
            end
            state_d = S_BUSY;
          end else begin
            result_d  = sc_res;
            zero_d    = (sc_res == '0);
            illegal_d = ~is_legal_single(op);
`ifdef SEQ_ALU_OVF_EN
            ovf_d     = ((op == OP_ADD) && add_ovf(a, b)) ||
                        ((op == OP_SUB) && sub_ovf(a, b));
`endif
            state_d   = S_DONE;
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (opsel_q[1]) begin
          acc_d = div_acc_n;
          lo_d  = div_lo_n;
        end else begin
          acc_d = mul_acc_n;
          lo_d  = mul_lo_n;
        end
        // Last iteration: its outcome goes straight to the result register.
        if (cnt_q == CW'(1)) begin
          result_d  = fin_res;
          zero_d    = (fin_res == '0);
          illegal_d = 1'b0;
`ifdef SEQ_ALU_OVF_EN
          ovf_d     = 1'b0;
`endif
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opsel_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opsel_q   <= opsel_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef SEQ_ALU_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
`ifdef SEQ_ALU_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu : scoreboard bench for seq_alu (WIDTH=32).
// The driver pushes the reference result for every accepted operation; the
// monitor pops and compares when out_valid first rises for a transaction.
// ---------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W     = 32;
  localparam int CLK_P = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
`ifdef SEQ_ALU_OVF_EN
  logic         overflow;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
`ifdef SEQ_ALU_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #(CLK_P/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic seen     = 1'b0;
  logic bp       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the op-code table.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int acc);
    exp_t           e;
    longint         sx, sy, s, lim;
    logic [2*W-1:0] prod;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    lim  = longint'(1) << (W - 1);
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.op  = o;
    e.res = '0;
    e.ill = 1'b0;
    e.ovf = 1'b0;
    e.lat = 1;
    e.acc = acc;
    case (o)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin s = sx + sy; e.res = W'(s); e.ovf = (s >= lim) || (s < -lim); end
      4'b0100: e.res = x ^ y;
      4'b0101: e.res = x << (y % W);
      4'b0110: begin s = sx - sy; e.res = W'(s); e.ovf = (s >= lim) || (s < -lim); end
      4'b0111: e.res = (sx < sy) ? W'(1) : W'(0);
      4'b1101: e.res = W'(sx >>> (y % W));
      4'b1000: begin e.res = prod[W-1:0];   e.lat = W + 1; end
      4'b1001: begin e.res = prod[2*W-1:W]; e.lat = W + 1; end
      4'b1010: begin e.res = (y == 0) ? '1 : x / y; e.lat = W + 1; end
      4'b1011: begin e.res = (y == 0) ? x : x % y;  e.lat = W + 1; end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Monitor: compare on the first out_valid cycle of each transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got result 0x%0h with empty scoreboard", result);
        end else begin
          mon_e = q.pop_front();
          check($sformatf("result op=%b", mon_e.op),  64'(result),  64'(mon_e.res));
          check($sformatf("zero op=%b", mon_e.op),    64'(zero),    64'(mon_e.zero));
          check($sformatf("illegal op=%b", mon_e.op), 64'(illegal), 64'(mon_e.ill));
`ifdef SEQ_ALU_OVF_EN
          check($sformatf("overflow op=%b", mon_e.op), 64'(overflow), 64'(mon_e.ovf));
`endif
          check($sformatf("latency op=%b", mon_e.op), 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
        end
      end
      if (out_ready) seen = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_result"},    64'(result),    64'(0));
    check({tag, "_zero"},      64'(zero),      64'(1));
    check({tag, "_illegal"},   64'(illegal),   64'(0));
`ifdef SEQ_ALU_OVF_EN
    check({tag, "_overflow"},  64'(overflow),  64'(0));
`endif
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!in_ready && guard < 300) begin
      if (bp) out_ready = ($urandom_range(2) != 0);
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end else begin
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      q.push_back(model(o, x, y, cyc + 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'($urandom_range(15));
      a  = $urandom;
      b  = $urandom;
    end
  endtask

  // Watch a multi-cycle op from the accept edge until out_valid.
  task automatic watch_busy(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) bad++;
    end
    check({tag, "_in_ready_low_busy"}, 64'(bad), 64'(0));
    check({tag, "_completes"}, 64'(out_valid), 64'(1));
  endtask

  task automatic run_dir(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y);
    if (o[3:2] == 2'b10) watch_busy($sformatf("op%b", o));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(4))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(15));
      3:       return {1'b1, W'($urandom) >> 1};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] bp_exp;
    int           guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Directed single-cycle, multiply, divide and illegal cases.
    run_dir(4'b0010, 32'h7FFF_FFFF, 32'h1);
    run_dir(4'b0110, 32'd5, 32'd5);
    run_dir(4'b0110, 32'h8000_0000, 32'h1);
    run_dir(4'b1101, 32'h8000_0000, 32'h24);
    run_dir(4'b0101, 32'h1, 32'd31);
    run_dir(4'b0111, 32'hFFFF_FFFF, 32'h1);
    run_dir(4'b0111, 32'h1, 32'hFFFF_FFFF);
    run_dir(4'b1000, 32'hFFFF_FFFF, 32'h2);
    run_dir(4'b1001, 32'hFFFF_FFFF, 32'h2);
    run_dir(4'b1010, 32'd100, 32'd7);
    run_dir(4'b1011, 32'd100, 32'd7);
    run_dir(4'b1010, 32'd9, 32'd0);
    run_dir(4'b1011, 32'd9, 32'd0);
    run_dir(4'b1111, 32'h1234, 32'h5678);
    run_dir(4'b0011, 32'hFFFF_FFFF, 32'h1);
    run_dir(4'b1100, 32'h5, 32'h5);
    run_dir(4'b1110, 32'h0, 32'h0);

    // Backpressure: hold the result in DONE while upstream keeps requesting.
    issue(4'b0010, 32'd10, 32'd20);
    out_ready = 1'b0;
    bp_exp = model(4'b0010, 32'd10, 32'd20, 0).res;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result_stable", 64'(result), 64'(bp_exp));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b1;
      op = 4'b0000;
      a  = $urandom;
      b  = $urandom;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset in the tenth cycle of a divide.
    issue(4'b1010, 32'hDEAD_BEEF, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    q.delete();
    repeat (2) @(negedge clk);
    check_reset_vals("midreset_hold");
    rst_n = 1'b1;
    issue(4'b0010, 32'd2, 32'd3);

    // Random operations with random output backpressure.
    bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      issue(4'($urandom_range(15)), pick(), pick());
    end
    bp = 1'b0;
    out_ready = 1'b1;

    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 64'(q.size()), 64'(0));
    repeat (2) @(negedge clk);
    check("final_idle", 64'(in_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
